// File: rtl/sipp_rf_sequencer.sv
// sipp_rf_sequencer: command-driven execute sequencer for the SIPP datapath.
// Fetches two operands from a 2R/1W register file, computes an ALU result and
// writes it back, one command per four cycles (IDLE -> READ -> EXEC -> WRITE).
module sipp_rf_sequencer #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    input  logic [ADDR_WIDTH-1:0] cmd_src_p,
    input  logic [ADDR_WIDTH-1:0] cmd_src_q,
    input  logic [DATA_WIDTH-1:0] cmd_imm,

    output logic [ADDR_WIDTH-1:0] rf_p_addr,
    output logic [ADDR_WIDTH-1:0] rf_q_addr,
    output logic                  rf_p_rd,
    output logic                  rf_q_rd,
    input  logic [DATA_WIDTH-1:0] rf_p_data,
    input  logic [DATA_WIDTH-1:0] rf_q_data,

    output logic [ADDR_WIDTH-1:0] rf_w_addr,
    output logic [DATA_WIDTH-1:0] rf_w_data,
    output logic                  rf_w_wr,

    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  flag_z,
    output logic                  flag_n
);

    // Shift amount uses only the low log2(DATA_WIDTH) bits of operand q.
    localparam int unsigned ShW = $clog2(DATA_WIDTH);

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpXor  = 4'd4;
    localparam logic [3:0] OpNot  = 4'd5;
    localparam logic [3:0] OpShl  = 4'd6;
    localparam logic [3:0] OpShr  = 4'd7;
    localparam logic [3:0] OpMov  = 4'd8;
    localparam logic [3:0] OpLdi  = 4'd9;
    localparam logic [3:0] OpAddi = 4'd10;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StExec,
        StWrite
    } state_e;

    state_e                state_q, state_d;

    logic [3:0]            op_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [ADDR_WIDTH-1:0] src_p_q;
    logic [ADDR_WIDTH-1:0] src_q_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [DATA_WIDTH-1:0] opnd_p_q;
    logic [DATA_WIDTH-1:0] opnd_q_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  flag_z_q;
    logic                  flag_n_q;

    logic                  op_legal;
    logic                  uses_p;
    logic                  uses_q;
    logic [ShW-1:0]        shamt;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  accept;

    // Operand-usage decode of the latched opcode.
    always_comb begin
        op_legal = (op_q <= OpAddi);
        uses_p   = op_legal && (op_q != OpLdi);
        uses_q   = (op_q <= OpXor) || (op_q == OpShl) || (op_q == OpShr);
    end

    // ALU on the captured operands; illegal opcodes yield zero (never written).
    always_comb begin
        alu_res = '0;
        shamt   = opnd_q_q[ShW-1:0];
        case (op_q)
            OpAdd:   alu_res = opnd_p_q + opnd_q_q;
            OpSub:   alu_res = opnd_p_q - opnd_q_q;
            OpAnd:   alu_res = opnd_p_q & opnd_q_q;
            OpOr:    alu_res = opnd_p_q | opnd_q_q;
            OpXor:   alu_res = opnd_p_q ^ opnd_q_q;
            OpNot:   alu_res = ~opnd_p_q;
            OpShl:   alu_res = opnd_p_q << shamt;
            OpShr:   alu_res = opnd_p_q >> shamt;
            OpMov:   alu_res = opnd_p_q;
            OpLdi:   alu_res = imm_q;
            OpAddi:  alu_res = opnd_p_q + imm_q;
            default: alu_res = '0;
        endcase
    end

    // Next-state and output decode from the registered state.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        rf_p_addr = '0;
        rf_q_addr = '0;
        rf_p_rd   = 1'b0;
        rf_q_rd   = 1'b0;
        rf_w_addr = '0;
        rf_w_data = '0;
        rf_w_wr   = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        accept    = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = StRead;
                end
            end
            StRead: begin
                // Unused ports stay fully quiet: rd low and address zero.
                rf_p_rd   = uses_p;
                rf_q_rd   = uses_q;
                rf_p_addr = uses_p ? src_p_q : '0;
                rf_q_addr = uses_q ? src_q_q : '0;
                state_d   = StExec;
            end
            StExec: begin
                state_d = StWrite;
            end
            StWrite: begin
                done = 1'b1;
                if (op_legal) begin
                    rf_w_wr   = 1'b1;
                    rf_w_addr = dst_q;
                    rf_w_data = result_q;
                end else begin
                    err = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        flag_z = flag_z_q;
        flag_n = flag_n_q;
    end

    // State register; reset from any state aborts the command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch, loaded only on the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= '0;
            dst_q   <= '0;
            src_p_q <= '0;
            src_q_q <= '0;
            imm_q   <= '0;
        end else if (accept) begin
            op_q    <= cmd_op;
            dst_q   <= cmd_dst;
            src_p_q <= cmd_src_p;
            src_q_q <= cmd_src_q;
            imm_q   <= cmd_imm;
        end
    end

    // Operand capture at the end of READ; masked so an unused port reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            opnd_p_q <= '0;
            opnd_q_q <= '0;
        end else if (state_q == StRead) begin
            opnd_p_q <= uses_p ? rf_p_data : '0;
            opnd_q_q <= uses_q ? rf_q_data : '0;
        end
    end

    // Result capture at the end of EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else if (state_q == StExec) begin
            result_q <= alu_res;
        end
    end

    // Flags follow the value committed by a legal write; illegal ops leave them alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else if ((state_q == StWrite) && op_legal) begin
            flag_z_q <= (result_q == '0);
            flag_n_q <= result_q[DATA_WIDTH-1];
        end
    end

endmodule

// File: doc/sipp_rf_sequencer.md
Name: sipp_rf_sequencer

Overview:
Command-driven execute sequencer for the SIPP datapath. It is the initiator side of the 2-read/1-write register file interface. It accepts one ALU command per handshake and drives the register file read ports p and q to fetch operands. It then computes the result and drives the write port for one cycle to write the result back. It also reports completion, an illegal-op error, and zero/negative flags.

Parameters:
ADDR_WIDTH, 4, register address width in bits
DATA_WIDTH, 16, data width in bits; must be a power of two and at least 4

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  4  opcode
cmd_dst  in  ADDR_WIDTH  destination register
cmd_src_p  in  ADDR_WIDTH  source register p
cmd_src_q  in  ADDR_WIDTH  source register q
cmd_imm  in  DATA_WIDTH  immediate value
rf_p_addr  out  ADDR_WIDTH  register file read address p
rf_q_addr  out  ADDR_WIDTH  register file read address q
rf_p_rd  out  1  read enable p
rf_q_rd  out  1  read enable q
rf_p_data  in  DATA_WIDTH  read data p; combinational from address (0 when rf_p_rd=0)
rf_q_data  in  DATA_WIDTH  read data q; combinational from address (0 when rf_q_rd=0)
rf_w_addr  out  ADDR_WIDTH  write address
rf_w_data  out  DATA_WIDTH  write data
rf_w_wr  out  1  write enable
busy  out  1  high whenever the state is not IDLE
done  out  1  one-cycle pulse when a command retires
err  out  1  one-cycle pulse when an illegal opcode retires
flag_z  out  1  last written result == 0
flag_n  out  1  MSB of last written result

Behaviour:
- Reset, synchronous, active-high:
  - state goes to IDLE.
  - All outputs are 0 except cmd_ready, which is 1.
  - Latched command, operand and result registers are cleared.
  - Reset in any state aborts the command. No rf_w_wr is issued afterwards.
- Opcodes:
  - 0 ADD p+q
  - 1 SUB p-q
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT p
  - 6 SHL p<<q[log2(DATA_WIDTH)-1:0]
  - 7 SHR, logical, same shift-amount rule as SHL
  - 8 MOV p
  - 9 LDI imm
  - 10 ADDI p+imm
  - 11-15 illegal
- Arithmetic is modulo 2^DATA_WIDTH. Carry and borrow are discarded.
- Read-enable usage:
  - p is used by every legal opcode except LDI.
  - q is used by opcodes 0-4, 6 and 7.
  - An unused port keeps its rd=0 and its addr=0.
- FSM states: IDLE -> READ -> EXEC -> WRITE -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch op/dst/src_p/src_q/imm and go to READ.
  - A command is never accepted outside IDLE.
- READ, one cycle:
  - Drive rf_p_addr/rf_q_addr and rf_p_rd/rf_q_rd from the latched command.
  - At the end of the cycle, capture rf_p_data/rf_q_data into the operand registers.
  - Go to EXEC.
- EXEC, one cycle:
  - Compute the result from the captured operands and the latched immediate into the result register.
  - Go to WRITE.
- WRITE, one cycle:
  - Legal op: rf_w_wr=1, rf_w_addr=dst, rf_w_data=result, done=1.
  - flag_z and flag_n update at the closing edge.
  - Illegal op: rf_w_wr=0, err=1, done=1, flags unchanged.
  - Go to IDLE.
- Outputs rf_*_rd, rf_w_wr, done and err are registered state decodes. They are 0 in every state other than the one listed above.
- Latency: for a command accepted at edge T, the write occurs in the cycle after edge T+2 and commits at edge T+3. cmd_ready returns at T+3. Throughput is 1 command per 4 cycles.
- Hazards:
  - Back-to-back dependent commands need no forwarding. The write commits before the next READ.
  - dst may equal src_p or src_q.
  - Register 0 is an ordinary register.
- cmd_* inputs are ignored outside the accepting edge. Changing them mid-command has no effect.

Test Plan:
- Reset with rst=1 for 2 cycles -> cmd_ready=1, busy=0, rf_w_wr=0, flag_z=0, flag_n=0.
- LDI dst=3 imm=0x1234 -> rf_p_rd=0 and rf_q_rd=0 in READ; rf_w_wr=1, w_addr=3, w_data=0x1234 exactly 3 cycles after the accept edge; done pulses one cycle; flag_z=0, flag_n=0.
- Register file model with R1=0xFFFF, R2=0x0001: ADD dst=4 p=1 q=2 -> rf_p_addr=1, rf_q_addr=2 in READ; write 0x0000 to R4; flag_z=1. Then SUB dst=5 p=4 q=2 -> write 0xFFFF; flag_n=1, flag_z=0.
- R6=0x8001, R7=0x0011: SHL dst=6 p=6 q=7 -> write 0x0002 to R6 (shift 1, q low 4 bits). SHR p=6 q=7 on the original value -> 0x4000.
- cmd_op=12 -> no rf_w_wr; err=1 and done=1 for one cycle; flags unchanged. cmd_valid held high during busy -> no second accept until cmd_ready=1.
- Accept ADD, assert rst in the EXEC cycle -> no rf_w_wr at any later cycle; next cycle is IDLE with cmd_ready=1. A new LDI then executes normally.
